fmrv32im_encode: RTL and testbench



---
 rtl/fmrv32im_pkg.sv | 34 +++
 rtl/fmrv32im_encode_fifo.sv | 57 +++++
 rtl/fmrv32im_encode.sv | 83 ++++++++
 tb/tb_fmrv32im_encode.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fmrv32im_pkg.sv
// fmrv32im_pkg: op ids, base opcodes and func fields shared by the RV32IM encoder
package fmrv32im_pkg;
  localparam int ENTRY_W = 33;
  localparam logic [5:0] OP_LUI = 6'd0, OP_AUIPC = 6'd1, OP_JAL = 6'd2, OP_JALR = 6'd3;
  localparam logic [5:0] OP_BEQ = 6'd4, OP_BNE = 6'd5, OP_BLT = 6'd6, OP_BGE = 6'd7;
  localparam logic [5:0] OP_BLTU = 6'd8, OP_BGEU = 6'd9;
  localparam logic [5:0] OP_LB = 6'd10, OP_LH = 6'd11, OP_LW = 6'd12, OP_LBU = 6'd13, OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB = 6'd15, OP_SH = 6'd16, OP_SW = 6'd17;
  localparam logic [5:0] OP_ADDI = 6'd18, OP_SLTI = 6'd19, OP_SLTIU = 6'd20, OP_XORI = 6'd21;
  localparam logic [5:0] OP_ORI = 6'd22, OP_ANDI = 6'd23, OP_SLLI = 6'd24, OP_SRLI = 6'd25, OP_SRAI = 6'd26;
  localparam logic [5:0] OP_ADD = 6'd27, OP_SUB = 6'd28, OP_SLL = 6'd29, OP_SLT = 6'd30, OP_SLTU = 6'd31;
  localparam logic [5:0] OP_XOR = 6'd32, OP_SRL = 6'd33, OP_SRA = 6'd34, OP_OR = 6'd35, OP_AND = 6'd36;
  localparam logic [5:0] OP_FENCE = 6'd37, OP_FENCEI = 6'd38, OP_ECALL = 6'd39, OP_EBREAK = 6'd40;
  localparam logic [5:0] OP_MRET = 6'd41, OP_CSRRW = 6'd42, OP_CSRRS = 6'd43, OP_CSRRC = 6'd44;
  localparam logic [5:0] OP_CSRRWI = 6'd45, OP_CSRRSI = 6'd46, OP_CSRRCI = 6'd47;
  localparam logic [5:0] OP_MUL = 6'd48, OP_REMU = 6'd55, OP_CUSTOM0 = 6'd56;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111, OPC_SYSTEM = 7'b1110011, OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;
  function automatic logic [2:0] funct3(input logic [5:0] op);
    case (op)
      OP_BNE, OP_LH, OP_SH, OP_SLLI, OP_SLL, OP_FENCEI, OP_CSRRW: return 3'd1;
      OP_LW, OP_SW, OP_SLTI, OP_SLT, OP_CSRRS: return 3'd2;
      OP_SLTIU, OP_SLTU, OP_CSRRC: return 3'd3;
      OP_BLT, OP_LBU, OP_XORI, OP_XOR: return 3'd4;
      OP_BGE, OP_LHU, OP_SRLI, OP_SRAI, OP_SRL, OP_SRA, OP_CSRRWI: return 3'd5;
      OP_BLTU, OP_ORI, OP_OR, OP_CSRRSI: return 3'd6;
      OP_BGEU, OP_ANDI, OP_AND, OP_CSRRCI: return 3'd7;
      default: return (op >= OP_MUL && op <= OP_REMU) ? op[2:0] : 3'd0;
    endcase
  endfunction
endpackage

// File: rtl/fmrv32im_encode_fifo.sv
// fmrv32im_encode_fifo: DEPTH-entry synchronous FIFO of {err,word} with flush and occupancy
module fmrv32im_encode_fifo import fmrv32im_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count
);
  localparam int AW = $clog2(DEPTH);
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign count = cnt_q;
  assign rd_data = empty ? '0 : mem_q[rp_q];
  always_comb begin
    mem_d = mem_q;
    wp_d = wp_q;
    rp_d = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
      cnt_d = '0;
    end else begin
      if (push) mem_d[wp_q] = wr_data;
      wp_d = push ? wp_q + AW'(1) : wp_q;
      rp_d = pop ? rp_q + AW'(1) : rp_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
    if (!RST_N) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fmrv32im_encode.sv
// fmrv32im_encode: RV32IM instruction encoder feeding a buffered valid/ready stream
module fmrv32im_encode import fmrv32im_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          FLUSH,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [5:0]    IN_OP,
  input  logic [4:0]    IN_RD,
  input  logic [4:0]    IN_RS1,
  input  logic [4:0]    IN_RS2,
  input  logic [31:0]   IN_IMM,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [31:0]   OUT_INST,
  output logic          OUT_ERR,
  output logic [CW-1:0] COUNT
);
  logic [31:0] w;
  logic e, s12, s13, s21, full, empty;
  logic [2:0] f3;
  logic [6:0] f7;
  assign s12 = IN_IMM[31:11] == '0 || IN_IMM[31:11] == '1;
  assign s13 = IN_IMM[31:12] == '0 || IN_IMM[31:12] == '1;
  assign s21 = IN_IMM[31:20] == '0 || IN_IMM[31:20] == '1;
  assign f3 = funct3(IN_OP);
  assign f7 = (IN_OP == OP_SUB || IN_OP == OP_SRA) ? F7_ALT : IN_OP >= OP_MUL ? F7_MULDIV : F7_BASE;
  always_comb begin
    w = '0;
    e = 1'b0;
    if (IN_OP == OP_LUI || IN_OP == OP_AUIPC) begin
      w = {IN_IMM[31:12], IN_RD, IN_OP == OP_LUI ? OPC_LUI : OPC_AUIPC};
      e = |IN_IMM[11:0];
    end else if (IN_OP == OP_JAL) begin
      w = {IN_IMM[20], IN_IMM[10:1], IN_IMM[11], IN_IMM[19:12], IN_RD, OPC_JAL};
      e = !s21 || IN_IMM[0];
    end else if (IN_OP == OP_JALR || IN_OP inside {[OP_LB:OP_LHU]} || IN_OP inside {[OP_ADDI:OP_ANDI]}) begin
      w = {IN_IMM[11:0], IN_RS1, f3, IN_RD, IN_OP == OP_JALR ? OPC_JALR : IN_OP <= OP_LHU ? OPC_LOAD : OPC_OPIMM};
      e = !s12;
    end else if (IN_OP inside {[OP_BEQ:OP_BGEU]}) begin
      w = {IN_IMM[12], IN_IMM[10:5], IN_RS2, IN_RS1, f3, IN_IMM[4:1], IN_IMM[11], OPC_BRANCH};
      e = !s13 || IN_IMM[0];
    end else if (IN_OP inside {[OP_SB:OP_SW]}) begin
      w = {IN_IMM[11:5], IN_RS2, IN_RS1, f3, IN_IMM[4:0], OPC_STORE};
      e = !s12;
    end else if (IN_OP inside {[OP_SLLI:OP_SRAI]}) begin
      w = {IN_OP == OP_SRAI ? F7_ALT : F7_BASE, IN_IMM[4:0], IN_RS1, f3, IN_RD, OPC_OPIMM};
      e = |IN_IMM[31:5];
    end else if (IN_OP inside {[OP_ADD:OP_AND]} || IN_OP inside {[OP_MUL:OP_REMU]}) begin
      w = {f7, IN_RS2, IN_RS1, f3, IN_RD, OPC_OP};
    end else if (IN_OP == OP_FENCE || IN_OP == OP_FENCEI) begin
      w = {IN_IMM[11:0], 5'd0, f3, 5'd0, OPC_MISCMEM};
      e = |IN_IMM[31:12];
    end else if (IN_OP inside {[OP_ECALL:OP_MRET]}) begin
      w = {IN_OP == OP_MRET ? 12'h302 : IN_OP == OP_EBREAK ? 12'h001 : 12'h000, 13'd0, OPC_SYSTEM};
    end else if (IN_OP inside {[OP_CSRRW:OP_CSRRCI]}) begin
      w = {IN_IMM[11:0], IN_RS1, f3, IN_RD, OPC_SYSTEM};
      e = |IN_IMM[31:12];
    end else if (IN_OP == OP_CUSTOM0) begin
      w = {IN_IMM[31:12], IN_RD, OPC_CUSTOM0};
      e = |IN_IMM[11:0];
    end else begin
      e = 1'b1;
    end
  end
  assign IN_READY = !full;
  assign OUT_VALID = !empty;
  fmrv32im_encode_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .CLK(CLK),
    .RST_N(RST_N),
    .flush(FLUSH),
    .wr_en(IN_VALID),
    .wr_data({e, e ? 32'h0 : w}),
    .rd_en(OUT_READY),
    .rd_data({OUT_ERR, OUT_INST}),
    .full(full),
    .empty(empty),
    .count(COUNT)
  );
endmodule

// File: tb/tb_fmrv32im_encode.sv
// tb_fmrv32im_encode: directed plus random checks of the encoder against a queue-based reference
module tb_fmrv32im_encode;
  localparam int DEPTH = 4;
  localparam int CW = 3;
  logic CLK = 1'b0, RST_N = 1'b0, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic IN_READY, OUT_VALID, OUT_ERR;
  logic [5:0] IN_OP = '0;
  logic [4:0] IN_RD = '0, IN_RS1 = '0, IN_RS2 = '0;
  logic [31:0] IN_IMM = '0, OUT_INST;
  logic [CW-1:0] COUNT;
  logic [32:0] q [$];
  int n_cmp = 0, n_bad = 0;
  int br_f3 [6] = '{0, 1, 4, 5, 6, 7};
  int ld_f3 [5] = '{0, 1, 2, 4, 5};
  int im_f3 [6] = '{0, 2, 3, 4, 6, 7};
  int r_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int cs_f3 [6] = '{1, 2, 3, 5, 6, 7};
  always #5 CLK = ~CLK;
  fmrv32im_encode #(.DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OP(IN_OP), .IN_RD(IN_RD), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_IMM(IN_IMM),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INST(OUT_INST), .OUT_ERR(OUT_ERR), .COUNT(COUNT)
  );
  function automatic logic [31:0] fld(input logic [31:0] v, input int lo);
    return v << lo;
  endfunction
  function automatic logic [32:0] model(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    int s = $signed(imm);
    int f3;
    logic [31:0] w = '0;
    bit e = 0;
    if (op <= 1) begin
      w = (imm & 32'hFFFFF000) | fld(rd, 7) | (op == 0 ? 32'h37 : 32'h17);
      e = (imm & 32'hFFF) != 0;
    end else if (op == 2) begin
      e = s < -1048576 || s > 1048575 || imm[0];
      w = fld(imm[20], 31) | fld(imm[10:1], 21) | fld(imm[11], 20) | fld(imm[19:12], 12) | fld(rd, 7) | 32'h6F;
    end else if (op == 3 || (op >= 10 && op <= 14) || (op >= 18 && op <= 23)) begin
      f3 = op == 3 ? 0 : op <= 14 ? ld_f3[op-10] : im_f3[op-18];
      e = s < -2048 || s > 2047;
      w = fld(imm & 32'hFFF, 20) | fld(rs1, 15) | fld(f3, 12) | fld(rd, 7) | (op == 3 ? 32'h67 : op <= 14 ? 32'h03 : 32'h13);
    end else if (op >= 4 && op <= 9) begin
      e = s < -4096 || s > 4095 || imm[0];
      w = fld(imm[12], 31) | fld(imm[10:5], 25) | fld(rs2, 20) | fld(rs1, 15) | fld(br_f3[op-4], 12)
        | fld(imm[4:1], 8) | fld(imm[11], 7) | 32'h63;
    end else if (op >= 15 && op <= 17) begin
      e = s < -2048 || s > 2047;
      w = fld(imm[11:5], 25) | fld(rs2, 20) | fld(rs1, 15) | fld(op - 15, 12) | fld(imm[4:0], 7) | 32'h23;
    end else if (op >= 24 && op <= 26) begin
      e = imm > 31;
      w = (op == 26 ? 32'h40000000 : 32'h0) | fld(imm[4:0], 20) | fld(rs1, 15) | fld(op == 24 ? 1 : 5, 12) | fld(rd, 7) | 32'h13;
    end else if ((op >= 27 && op <= 36) || (op >= 48 && op <= 55)) begin
      f3 = op >= 48 ? op - 48 : r_f3[op-27];
      w = (op == 28 || op == 34 ? 32'h40000000 : op >= 48 ? 32'h02000000 : 32'h0)
        | fld(rs2, 20) | fld(rs1, 15) | fld(f3, 12) | fld(rd, 7) | 32'h33;
    end else if (op == 37 || op == 38) begin
      e = imm > 32'hFFF;
      w = fld(imm & 32'hFFF, 20) | fld(op - 37, 12) | 32'h0F;
    end else if (op == 39) w = 32'h00000073;
    else if (op == 40) w = 32'h00100073;
    else if (op == 41) w = 32'h30200073;
    else if (op >= 42 && op <= 47) begin
      e = imm > 32'hFFF;
      w = fld(imm & 32'hFFF, 20) | fld(rs1, 15) | fld(cs_f3[op-42], 12) | fld(rd, 7) | 32'h73;
    end else if (op == 56) begin
      e = (imm & 32'hFFF) != 0;
      w = (imm & 32'hFFFFF000) | fld(rd, 7) | 32'h0B;
    end else e = 1;
    return {e, e ? 32'h0 : w};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_state();
    chk("count", 64'(COUNT), 64'(q.size()));
    chk("out_valid", 64'(OUT_VALID), 64'(q.size() > 0));
    chk("in_ready", 64'(IN_READY), 64'(q.size() < DEPTH));
    if (q.size() > 0) begin
      chk("head_inst", 64'(OUT_INST), 64'(q[0][31:0]));
      chk("head_err", 64'(OUT_ERR), 64'(q[0][32]));
    end else begin
      chk("empty_inst", 64'(OUT_INST), 64'h0);
      chk("empty_err", 64'(OUT_ERR), 64'h0);
    end
  endtask
  task automatic step();
    bit acc, pop;
    logic [32:0] ent;
    acc = IN_VALID && q.size() < DEPTH;
    pop = OUT_READY && q.size() > 0;
    ent = model(int'(IN_OP), IN_RD, IN_RS1, IN_RS2, IN_IMM);
    @(posedge CLK);
    #1;
    if (!RST_N || FLUSH) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ent);
    end
    check_state();
  endtask
  task automatic drive(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    IN_OP = 6'(op);
    IN_RD = 5'(rd);
    IN_RS1 = 5'(rs1);
    IN_RS2 = 5'(rs2);
    IN_IMM = imm;
    IN_VALID = 1'b1;
  endtask
  task automatic drive_rand();
    int k = $urandom_range(0, 3);
    drive(($urandom_range(0, 7) == 0) ? $urandom_range(57, 63) : $urandom_range(0, 56),
          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          k == 0 ? 32'($urandom_range(0, 4095)) - 32'd2048 : k == 1 ? $urandom :
          k == 2 ? ($urandom & 32'hFFFFF000) : 32'($urandom_range(0, 63)));
  endtask
  initial begin
    step();
    RST_N = 1'b1;
    step();
    OUT_READY = 1'b1;
    drive(18, 1, 0, 0, 32'hFFFFFFFF);
    step();
    chk("addi_valid", 64'(OUT_VALID), 64'h1);
    chk("addi_inst", 64'(OUT_INST), 64'hFFF00093);
    chk("addi_err", 64'(OUT_ERR), 64'h0);
    drive(4, 0, 1, 2, 32'd8);
    step();
    chk("beq_inst", 64'(OUT_INST), 64'h00208463);
    drive(4, 0, 1, 2, 32'd7);
    step();
    chk("beq_odd_inst", 64'(OUT_INST), 64'h0);
    chk("beq_odd_err", 64'(OUT_ERR), 64'h1);
    drive(0, 5, 0, 0, 32'h12345000);
    step();
    chk("lui_inst", 64'(OUT_INST), 64'h123452B7);
    drive(26, 3, 3, 0, 32'd7);
    step();
    chk("srai_inst", 64'(OUT_INST), 64'h4071D193);
    drive(41, 7, 7, 0, 32'h55);
    step();
    chk("mret_inst", 64'(OUT_INST), 64'h30200073);
    drive(60, 1, 1, 1, 32'h0);
    step();
    chk("bad_op_err", 64'(OUT_ERR), 64'h1);
    IN_VALID = 1'b0;
    step();
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(27 + i, i + 1, i + 2, i + 3, 32'h0);
      step();
      if (i == 3) begin
        chk("full_count", 64'(COUNT), 64'd4);
        chk("full_ready", 64'(IN_READY), 64'h0);
      end
    end
    OUT_READY = 1'b1;
    step();
    chk("ready_back", 64'(IN_READY), 64'h1);
    IN_VALID = 1'b0;
    repeat (4) step();
    OUT_READY = 1'b0;
    drive(12, 4, 5, 0, 32'h7FC);
    step();
    drive(17, 0, 6, 7, 32'hFFFFF800);
    step();
    OUT_READY = 1'b1;
    drive(2, 1, 0, 0, 32'hFFF00000);
    step();
    chk("pushpop_count", 64'(COUNT), 64'd2);
    FLUSH = 1'b1;
    step();
    chk("flush_count", 64'(COUNT), 64'd0);
    chk("flush_valid", 64'(OUT_VALID), 64'h0);
    FLUSH = 1'b0;
    OUT_READY = 1'b0;
    repeat (3) begin
      drive_rand();
      step();
    end
    IN_VALID = 1'b0;
    RST_N = 1'b0;
    step();
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_valid", 64'(OUT_VALID), 64'h0);
    chk("rst_inst", 64'(OUT_INST), 64'h0);
    RST_N = 1'b1;
    drive(27, 1, 2, 3, 32'h0);
    step();
    chk("post_rst_inst", 64'(OUT_INST), 64'h003100B3);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive_rand();
      else IN_VALID = 1'b0;
      OUT_READY = $urandom_range(0, 2) != 0;
      FLUSH = $urandom_range(0, 31) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
